// File: rtl/softex_minmax_sched.sv
// softex_minmax_sched
// Sequencing controller for the global min/max tracker. It takes a row
// command and runs the tracker through clear, optional preload, stream and
// drain. It then reports the final extremum with a one-cycle done pulse.
//
// Ports
//   clk_i, rst_ni                  clock, async active-low reset
//   clear_i                        synchronous abort back to IDLE
//   start_i, length_i, mode_i      row command (sampled in IDLE only)
//   init_en_i, init_val_i          optional tracker preload
//   in_valid_i / in_ready_o        streamer beat handshake
//   mm_*_o                         tracker controls, strobe and preload value
//   mm_ready_i, mm_new_flg_i,
//   mm_cur_minmax_i                tracker status
//   busy_o, done_o, result_o       status and final extremum
//   upd_cnt_o                      running-extremum update count (saturating)
//
// WIDTH is the element width of the tracker's FP format (16 for FP16).
// mode_i / mm_operation_o use 1'b0 = MAX and 1'b1 = MIN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start_i
// S_CLEAR  | one cycle: tracker reset to -inf (MAX) / +inf (MIN)
// S_LOAD   | one cycle: tracker preloaded with init_val
// S_STREAM | beats forwarded; strobe trimmed on a partial last beat
// S_DRAIN  | NUM_REGS+1 cycles: tracker pipeline empties, result captured
// S_DONE   | one-cycle done pulse
module softex_minmax_sched #(
  parameter int WIDTH      = 16,
  parameter int VECT_WIDTH = 4,
  parameter int NUM_REGS   = 0,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  input  logic                  mode_i,
  input  logic                  init_en_i,
  input  logic [WIDTH-1:0]      init_val_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic                  mm_clear_o,
  output logic                  mm_enable_o,
  output logic                  mm_valid_o,
  output logic                  mm_ready_o,
  output logic                  mm_load_en_o,
  output logic                  mm_operation_o,
  output logic [VECT_WIDTH-1:0] mm_strb_o,
  output logic [WIDTH-1:0]      mm_load_o,
  input  logic                  mm_ready_i,
  input  logic                  mm_new_flg_i,
  input  logic [WIDTH-1:0]      mm_cur_minmax_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [WIDTH-1:0]      result_o,
  output logic [CNT_WIDTH-1:0]  upd_cnt_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int REM_W = (VECT_WIDTH > 1) ? $clog2(VECT_WIDTH) : 1;
  localparam int DRN_W = (NUM_REGS > 0) ? $clog2(NUM_REGS + 1) : 1;

  logic [2:0]           state, state_nxt;
  logic                 mode_q, init_en_q;
  logic [WIDTH-1:0]     init_val_q;
  logic [LEN_WIDTH-1:0] beats_q, beat_cnt;
  logic [REM_W-1:0]     rem_q;
  logic [DRN_W-1:0]     drain_cnt;
  logic [WIDTH-1:0]     result_q;
  logic [CNT_WIDTH-1:0] upd_cnt_q;

  logic [LEN_WIDTH-1:0] len_rem, beats_in;
  logic                 start_cmd, in_stream, in_drain, accept, last_beat, drain_last;

  // beats = ceil(length / VECT_WIDTH) without the overflow of length+VW-1
  assign len_rem  = length_i % LEN_WIDTH'(VECT_WIDTH);
  assign beats_in = (length_i / LEN_WIDTH'(VECT_WIDTH)) +
                    {{(LEN_WIDTH-1){1'b0}}, (len_rem != '0)};

  assign start_cmd  = (state == S_IDLE) && start_i && !clear_i;
  assign in_stream  = (state == S_STREAM);
  assign in_drain   = (state == S_DRAIN);
  assign accept     = in_stream && in_valid_i && mm_ready_i;
  assign last_beat  = (beat_cnt == beats_q - LEN_WIDTH'(1));
  assign drain_last = (drain_cnt == DRN_W'(NUM_REGS));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_i) state_nxt = S_CLEAR;
      S_CLEAR:  begin
        if (init_en_q)            state_nxt = S_LOAD;
        else if (beats_q == '0)   state_nxt = S_DRAIN;
        else                      state_nxt = S_STREAM;
      end
      S_LOAD:   state_nxt = (beats_q == '0) ? S_DRAIN : S_STREAM;
      S_STREAM: if (accept && last_beat) state_nxt = S_DRAIN;
      S_DRAIN:  if (drain_last) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (clear_i) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      mode_q     <= 1'b0;
      init_en_q  <= 1'b0;
      init_val_q <= '0;
      beats_q    <= '0;
      rem_q      <= '0;
      beat_cnt   <= '0;
      drain_cnt  <= '0;
      result_q   <= '0;
      upd_cnt_q  <= '0;
    end else begin
      state <= state_nxt;

      if (start_cmd) begin
        mode_q     <= mode_i;
        init_en_q  <= init_en_i;
        init_val_q <= init_val_i;
        beats_q    <= beats_in;
        rem_q      <= len_rem[REM_W-1:0];
      end

      if (state == S_CLEAR) beat_cnt <= '0;
      else if (accept)      beat_cnt <= beat_cnt + LEN_WIDTH'(1);

      if (in_drain) drain_cnt <= drain_cnt + DRN_W'(1);
      else          drain_cnt <= '0;

      // an abort leaves the previous result and count untouched
      if (in_drain && drain_last && !clear_i) result_q <= mm_cur_minmax_i;

      if (start_cmd)
        upd_cnt_q <= '0;
      else if (!clear_i && (in_stream || in_drain) && mm_new_flg_i && (upd_cnt_q != '1))
        upd_cnt_q <= upd_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    mm_strb_o = '0;
    if (in_stream) begin
      mm_strb_o = '1;
      if (last_beat && (rem_q != '0)) begin
        for (int i = 0; i < VECT_WIDTH; i++) mm_strb_o[i] = (i < int'(rem_q));
      end
    end
  end

  assign busy_o         = (state != S_IDLE);
  assign mm_enable_o    = busy_o;
  assign done_o         = (state == S_DONE);
  assign mm_clear_o     = (state == S_CLEAR) || clear_i;
  assign mm_load_en_o   = (state == S_LOAD);
  assign mm_load_o      = init_val_q;
  assign mm_operation_o = mode_q;
  assign mm_valid_o     = in_stream && in_valid_i;
  assign in_ready_o     = in_stream && mm_ready_i;
  assign mm_ready_o     = in_stream || in_drain;
  assign result_o       = result_q;
  assign upd_cnt_o      = upd_cnt_q;

endmodule

// File: tb/tb_softex_minmax_sched.sv
module tb_softex_minmax_sched;
  localparam int NR = 1;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic clear_i = 0, start_i = 0, mode_i = 0, init_en_i = 0, in_valid_i = 0;
  logic [15:0] length_i = 0, init_val_i = 0;
  logic in_ready_o, mm_clear_o, mm_enable_o, mm_valid_o, mm_ready_o, mm_load_en_o, mm_operation_o;
  logic [3:0]  mm_strb_o;
  logic [15:0] mm_load_o, mm_cur_minmax_i, result_o;
  logic mm_ready_i = 1, mm_new_flg_i;
  logic busy_o, done_o;
  logic [7:0] upd_cnt_o;

  softex_minmax_sched #(.WIDTH(16), .VECT_WIDTH(4), .NUM_REGS(NR), .LEN_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i), .length_i(length_i),
    .mode_i(mode_i), .init_en_i(init_en_i), .init_val_i(init_val_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .mm_clear_o(mm_clear_o), .mm_enable_o(mm_enable_o),
    .mm_valid_o(mm_valid_o), .mm_ready_o(mm_ready_o), .mm_load_en_o(mm_load_en_o),
    .mm_operation_o(mm_operation_o), .mm_strb_o(mm_strb_o), .mm_load_o(mm_load_o),
    .mm_ready_i(mm_ready_i), .mm_new_flg_i(mm_new_flg_i), .mm_cur_minmax_i(mm_cur_minmax_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .upd_cnt_o(upd_cnt_o));

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [3:0][15:0] lanes = '0;
  logic [15:0] elems[$];
  int stall_q[$];
  logic [15:0] garb = 0;
  int obs_k;
  logic [15:0] obs_res, last_exp_res;
  logic [7:0]  obs_upd, last_exp_upd;
  logic [3:0]  obs_strb;
  logic [15:0] pool[8] = '{16'h3C00, 16'h4000, 16'hC000, 16'h4200, 16'hBC00, 16'h0000, 16'h4880, 16'hC700};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- tracker stand-in (FP16 ordered compare, one reduction stage)
  function automatic logic [15:0] okey(input logic [15:0] b);
    okey = b[15] ? ~b : (b | 16'h8000);
  endfunction
  function automatic bit tbetter(input logic [15:0] a, input logic [15:0] c, input logic op);
    tbetter = op ? (okey(a) < okey(c)) : (okey(a) > okey(c));
  endfunction
  function automatic logic [15:0] beat_ext(input logic [3:0][15:0] l, input logic [3:0] s, input logic op);
    logic [15:0] r = 0;
    bit have = 0;
    for (int i = 0; i < 4; i++)
      if (s[i] && (!have || tbetter(l[i], r, op))) begin r = l[i]; have = 1; end
    return r;
  endfunction

  logic sn_clear, sn_load_en, sn_valid, sn_ready, sn_op;
  logic [15:0] sn_load;
  logic [3:0]  sn_strb;
  logic [3:0][15:0] sn_lanes;
  always @(negedge clk_i) begin
    #2;
    sn_clear = mm_clear_o; sn_load_en = mm_load_en_o; sn_valid = mm_valid_o;
    sn_ready = mm_ready_i; sn_op = mm_operation_o; sn_load = mm_load_o;
    sn_strb = mm_strb_o; sn_lanes = lanes;
  end

  logic [15:0] tr_cur, tr_stg;
  logic tr_stg_v;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tr_cur <= 0; tr_stg <= 0; tr_stg_v <= 0;
    end else begin
      tr_stg_v <= sn_valid && sn_ready;
      tr_stg   <= beat_ext(sn_lanes, sn_strb, sn_op);
      if (sn_clear) begin
        tr_cur <= sn_op ? 16'h7C00 : 16'hFC00;
        tr_stg_v <= 0;
      end else if (sn_load_en) tr_cur <= sn_load;
      else if (tr_stg_v && tbetter(tr_stg, tr_cur, sn_op)) tr_cur <= tr_stg;
    end
  end
  assign mm_cur_minmax_i = tr_cur;
  assign mm_new_flg_i = tr_stg_v && tbetter(tr_stg, tr_cur, mm_operation_o);

  // ---------------- reference model in real arithmetic
  function automatic real f2r(input logic [15:0] b);
    int e = int'(b[14:10]);
    int m = int'(b[9:0]);
    real v = (e == 0) ? real'(m) : real'(1024 + m);
    int ex = (e == 0) ? -24 : e - 25;
    if (ex < 0) repeat (-ex) v = v / 2.0;
    else        repeat (ex)  v = v * 2.0;
    return b[15] ? -v : v;
  endfunction

  function automatic logic [15:0] rand_fp();
    logic [15:0] b;
    if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 7)];
    do b = 16'($urandom); while (b[14:10] == 5'h1F || b == 16'h8000);
    return b;
  endfunction

  task automatic run_row(input string tag, input logic mode, input logic ien, input logic [15:0] ival,
                         input int len, input bit rnd_start);
    int n = (len + 3) / 4;
    int rem = len % 4;
    int t, k = 0, bd = 0, nstall = 0, code;
    bit done_seen = 0, win;
    real ext_r, br;
    logic [15:0] ext_b, bb, exp_res;
    logic [3:0] exp_strb;
    int upd = 0;
    bit have = ien;
    ext_b = ival; ext_r = f2r(ival);
    for (int b = 0; b < n; b++) begin
      bb = elems[b*4]; br = f2r(bb);
      for (int i = b*4 + 1; i < b*4 + 4 && i < len; i++)
        if (mode ? f2r(elems[i]) < br : f2r(elems[i]) > br) begin bb = elems[i]; br = f2r(bb); end
      if (!have || (mode ? br < ext_r : br > ext_r)) begin
        ext_r = br; ext_b = bb; have = 1; upd++;
      end
    end
    exp_res = have ? ext_b : (mode ? 16'h7C00 : 16'hFC00);

    @(negedge clk_i);
    start_i = 1; mode_i = mode; init_en_i = ien; init_val_i = ival; length_i = 16'(len);
    t = cyc;
    while (!done_seen && k < 200) begin
      @(negedge clk_i);
      k = cyc - t;
      start_i = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
      mode_i = 1'($urandom); length_i = 16'($urandom);
      win = (k >= 2 + ien) && (bd < n);
      if (win) begin
        code = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
        in_valid_i = (code & 1) == 0;
        mm_ready_i = (code & 2) == 0;
        for (int i = 0; i < 4; i++)
          lanes[i] = (bd*4 + i < len) ? elems[bd*4 + i] : ((garb != 0) ? garb : 16'($urandom));
      end else begin
        in_valid_i = 1'($urandom_range(0, 1));
        mm_ready_i = 1;
        lanes = {$urandom, $urandom};
      end
      #1;
      if (win) begin
        check({tag, " in_ready"}, in_ready_o, mm_ready_i);
        check({tag, " mm_valid"}, mm_valid_o, in_valid_i);
        if (in_valid_i && mm_ready_i) begin
          exp_strb = (bd == n - 1 && rem != 0) ? 4'((1 << rem) - 1) : 4'hF;
          check({tag, " strb"}, mm_strb_o, exp_strb);
          obs_strb = mm_strb_o;
          bd++;
        end else nstall++;
      end else begin
        check({tag, " in_ready_off"}, in_ready_o, 0);
        check({tag, " mm_valid_off"}, mm_valid_o, 0);
      end
      if (k == 1) begin
        check({tag, " clear_pulse"}, mm_clear_o, 1);
        check({tag, " operation"}, mm_operation_o, mode);
      end
      if (k == 2) begin
        check({tag, " load_en"}, mm_load_en_o, ien);
        if (ien) check({tag, " load_val"}, mm_load_o, ival);
      end
      if (done_o) begin
        done_seen = 1;
        obs_k = k; obs_res = result_o; obs_upd = upd_cnt_o;
        check({tag, " done_cycle"}, k, 3 + ien + n + NR + nstall);
        check({tag, " result"}, result_o, exp_res);
        check({tag, " upd_cnt"}, upd_cnt_o, upd);
      end
    end
    check({tag, " done_seen"}, done_seen, 1);
    @(negedge clk_i);
    start_i = 0; in_valid_i = 0; mm_ready_i = 1;
    #1;
    check({tag, " idle_after"}, busy_o, 0);
    check({tag, " result_held"}, result_o, exp_res);
    last_exp_res = exp_res; last_exp_upd = 8'(upd);
  endtask

  initial begin
    elems.delete(); stall_q.delete();
    repeat (3) @(negedge clk_i);
    #1;
    check("rst busy", busy_o, 0);
    check("rst done", done_o, 0);
    check("rst mm_clear", mm_clear_o, 0);
    check("rst enable", mm_enable_o, 0);
    check("rst load_en", mm_load_en_o, 0);
    check("rst in_ready", in_ready_o, 0);
    check("rst operation", mm_operation_o, 0);
    check("rst result", result_o, 0);
    check("rst upd", upd_cnt_o, 0);
    @(negedge clk_i) rst_ni = 1;

    elems = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h0000, 16'h4880, 16'h4000, 16'h3C00};
    run_row("max8", 0, 0, 0, 8, 0);
    check("max8 k", obs_k, 6);
    check("max8 res", obs_res, 16'h4880);
    check("max8 upd", obs_upd, 2);

    elems = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'hC200, 16'hC700};
    garb = 16'hF000;
    run_row("min6", 1, 0, 0, 6, 0);
    check("min6 res", obs_res, 16'hC700);
    check("min6 strb", obs_strb, 4'b0011);
    garb = 0;

    elems = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800};
    run_row("preload", 0, 1, 16'h5640, 8, 0);
    check("preload k", obs_k, 7);
    check("preload res", obs_res, 16'h5640);
    check("preload upd", obs_upd, 0);

    elems.delete();
    run_row("zero", 0, 0, 0, 0, 0);
    check("zero k", obs_k, 4);
    check("zero res", obs_res, 16'hFC00);

    elems = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h0000, 16'h4880, 16'h4000, 16'h3C00};
    stall_q = '{0, 1, 1, 1, 2, 2};
    run_row("bp", 0, 0, 0, 8, 0);
    check("bp k", obs_k, 11);
    check("bp res", obs_res, 16'h4880);
    check("bp upd", obs_upd, 2);

    // clear_i wins over start_i in IDLE: nothing captured, count kept
    @(negedge clk_i); start_i = 1; clear_i = 1;
    #1 check("prio clear_pulse", mm_clear_o, 1);
    @(negedge clk_i); start_i = 0; clear_i = 0;
    #1;
    check("prio busy", busy_o, 0);
    check("prio upd kept", upd_cnt_o, last_exp_upd);

    // abort mid-stream after one beat
    @(negedge clk_i);
    start_i = 1; mode_i = 0; init_en_i = 0; length_i = 8;
    @(negedge clk_i); start_i = 0;
    @(negedge clk_i);
    lanes = {16'h4400, 16'h4200, 16'h4000, 16'h3C00}; in_valid_i = 1; mm_ready_i = 1;
    #1 check("abort in_ready", in_ready_o, 1);
    @(negedge clk_i); in_valid_i = 0;
    @(negedge clk_i); clear_i = 1;
    #1;
    check("abort mm_clear", mm_clear_o, 1);
    check("abort busy_pre", busy_o, 1);
    @(negedge clk_i); clear_i = 0;
    #1 check("abort busy_post", busy_o, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      #1 check("abort no_done", done_o, 0);
    end
    check("abort result kept", result_o, last_exp_res);
    check("abort upd kept", upd_cnt_o, 1);

    elems = '{16'h4500, 16'h4600, 16'h4700, 16'h4800};
    run_row("after_abort", 1, 0, 0, 4, 0);
    check("after_abort res", obs_res, 16'h4500);
    check("after_abort upd", obs_upd, 1);

    for (int r = 0; r < 25; r++) begin
      logic m, ie;
      logic [15:0] iv;
      int ln;
      m = 1'($urandom); ie = ($urandom_range(0, 3) == 0); iv = rand_fp();
      ln = $urandom_range(0, 19);
      elems.delete(); stall_q.delete();
      for (int i = 0; i < ln; i++) elems.push_back(rand_fp());
      for (int s = 0; s < ln / 4 + 3; s++)
        stall_q.push_back(($urandom_range(0, 9) < 3) ? $urandom_range(1, 3) : 0);
      run_row("rnd", m, ie, iv, ln, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/softex_minmax_sched.md
# softex_minmax_sched

Sequencing controller for the global min/max tracker (`softex_fp_glob_minmax`) in the softex datapath. It accepts a row-level command (length, mode, optional preload value) and drives the tracker through clear, preload, stream and drain phases. It generates per-beat strobes for partial last beats and reports the final min/max with a done pulse. It also counts running-extremum updates, so downstream normalisation knows how many rescales occurred.

## Interface
- `FPFORMAT`, default `FPFORMAT_IN`: element format; `WIDTH = fpnew_pkg::fp_width(FPFORMAT)`.
- `VECT_WIDTH`, default 4: elements per beat.
- `NUM_REGS`, default 0: pipeline depth of the tracker's reduction tree.
- `LEN_WIDTH`, default 16: width of the element-count command.
- `CNT_WIDTH`, default 8: width of the update counter.
---
- `clk_i`, in, 1: the single clock.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `clear_i`, in, 1: synchronous abort; the FSM returns to IDLE.
- `start_i`, in, 1: command strobe, sampled only in IDLE.
- `length_i`, in, LEN_WIDTH: number of elements in the row.
- `mode_i`, in, `min_max_mode_t`: MAX or MIN.
- `init_en_i`, in, 1: preload the tracker with `init_val_i` instead of ±inf.
- `init_val_i`, in, WIDTH: preload value.
- `in_valid_i`, in, 1: the streamer presents a beat.
- `in_ready_o`, out, 1: a beat is accepted when `in_valid_i & in_ready_o`.
- `mm_clear_o`, `mm_enable_o`, `mm_valid_o`, `mm_ready_o`, `mm_load_en_o`, out, 1 each: tracker controls.
- `mm_operation_o`, out, `min_max_mode_t`: latched mode.
- `mm_strb_o`, out, VECT_WIDTH: element strobe for the current beat.
- `mm_load_o`, out, WIDTH: preload value.
- `mm_ready_i`, `mm_new_flg_i`, in, 1 each: from the tracker.
- `mm_cur_minmax_i`, in, WIDTH: from the tracker.
- `busy_o`, out, 1: high whenever the FSM is not in IDLE.
- `done_o`, out, 1: one-cycle completion pulse.
- `result_o`, out, WIDTH: final extremum, held until the next start.
- `upd_cnt_o`, out, CNT_WIDTH: number of updates in the row, saturating.

## Operation
- **Command capture.** On `start_i` in IDLE, latch the following:
  - `mode_i`, `init_en_i` and `init_val_i`;
  - `beats = ceil(length_i / VECT_WIDTH)`;
  - `rem = length_i mod VECT_WIDTH`.
- **Command capture side effects.** In the same cycle, clear `upd_cnt_o`. Ignore `start_i` in every other state.
- **States.** IDLE → CLEAR → LOAD (only if `init_en`) → STREAM → DRAIN → DONE → IDLE.
- **CLEAR.** Exactly 1 cycle. `mm_clear_o=1`; `mm_operation_o` already shows the latched mode, so the tracker resets to −inf for MAX or +inf for MIN.
- **Zero-length rows.** If `beats==0`, CLEAR and LOAD skip STREAM and go to DRAIN.
- **LOAD.** Exactly 1 cycle. `mm_load_en_o=1`, `mm_load_o=init_val`.
- **STREAM.**
  - `mm_valid_o = in_valid_i`.
  - `in_ready_o = mm_ready_i`.
  - `mm_ready_o = 1`.
  - Beat counter increments on each accepted beat.
  - `mm_strb_o` is all ones, except on the last beat with `rem≠0`, where bits `[rem-1:0]` are set.
  - After the last accepted beat, go to DRAIN.
- **DRAIN.** Exactly NUM_REGS+1 cycles. `mm_valid_o=0`, `mm_ready_o=1`. On the final DRAIN cycle, `result_o <= mm_cur_minmax_i`.
- **DONE.** 1 cycle with `done_o=1`, then return to IDLE.
- **Enable.** `mm_enable_o = busy_o`.
- **Update counter.** `upd_cnt_o` increments on `mm_new_flg_i` during STREAM and DRAIN, and saturates at all ones.
- **Abort.** `clear_i` in any state:
  - next state is IDLE and `mm_clear_o=1` in that cycle;
  - no `done_o` is issued;
  - `result_o` and `upd_cnt_o` keep their values.
- **Priority.** `clear_i` has priority over `start_i`.
- **Outside STREAM.** `in_ready_o=0`.

## Timing
- **Reset values.** All control outputs are 0, `mm_operation_o=MAX`, `result_o=0`, `upd_cnt_o=0`, and the FSM is in IDLE.
- **Latency.** Let `start_i` be sampled at cycle t, L=`init_en`, and N=beats with no stalls:
  - CLEAR is at t+1;
  - the first STREAM cycle is t+2+L;
  - the last beat is accepted at t+1+L+N;
  - DRAIN spans t+2+L+N … t+2+L+N+NUM_REGS;
  - `done_o` is asserted at t+3+L+N+NUM_REGS.
- **Stalls.** Each cycle with `in_valid_i=0` or `mm_ready_i=0` adds one cycle.
- **Back-to-back commands.** The earliest next `start_i` is sampled in the cycle after DONE.

## Test plan
Bench configuration: FP16, VECT_WIDTH=4, NUM_REGS=1.
- **MAX, length 8, no stalls.** Beats {1,2,3,4} and {0,9,2,1} (as FP16), start at t=0 → `done_o` at t=6 and `result_o=9.0` (0x4880). `upd_cnt_o=2` counts both the first-beat update from −inf and the second-beat rise to 9.0.
- **MIN, length 6.** Second beat {−3,−7,x,x} → `mm_strb_o=4'b0011` on beat 2; `result_o=−7.0`; the garbage lanes must not affect the result.
- **Preload.** MAX with `init_en_i`, `init_val_i=100.0`, and all inputs below 100 → LOAD is seen at t+2, `result_o=100.0`, `upd_cnt_o=0`, `done_o` at t+7.
- **Zero-length row.** `length_i=0` → no `in_ready_o`, `done_o` at t+4, `result_o=0xFC00` (−inf).
- **Backpressure.** `in_valid_i` low for 3 cycles mid-row and `mm_ready_i` low for 2 cycles → `done_o` is delayed by exactly 5 cycles and the result is unchanged.
- **Abort.** `clear_i` in STREAM after 1 beat, then a new start → no `done_o` for the first row; the second row's result is independent of the first.
